// File: rtl/rdy_vld_fifo_if.sv
// Ready/valid handshake bundle. The source drives vld and vld_data, the destination drives rdy.
`timescale 1ns/1ps
interface rdy_vld_if #(
  parameter type vld_data_st = logic [1:0]
) ();
  logic       vld;
  logic       rdy;
  vld_data_st vld_data;

  modport src (output vld, output vld_data, input rdy);
  modport dst (input vld, input vld_data, output rdy);
endinterface

// File: rtl/rdy_vld_fifo.sv
// Ready/valid FIFO. in_if.rdy and out_if.vld both come straight from flops,
// so the FIFO also works as a register slice between pipeline stages.
`timescale 1ns/1ps
module rdy_vld_fifo #(
  parameter type         vld_data_st = logic [1:0],
  parameter int unsigned DEPTH       = 4,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  rdy_vld_if.dst           in_if,
  rdy_vld_if.src           out_if,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  vld_data_st       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_in_rdy;
  logic             r_out_vld;

  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_d;

  assign w_push = in_if.vld && r_in_rdy;
  assign w_pop  = r_out_vld && out_if.rdy;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CNT_W'(1);
      2'b01:   w_count_d = r_count - CNT_W'(1);
      default: w_count_d = r_count;
    endcase
  end

  // Handshake flags are computed from the next count so they never depend
  // combinationally on the partner's vld/rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count   <= w_count_d;
      r_in_rdy  <= (w_count_d != CNT_W'(DEPTH));
      r_out_vld <= (w_count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_if.vld_data;
  end

  assign in_if.rdy       = r_in_rdy;
  assign out_if.vld      = r_out_vld;
  assign out_if.vld_data = r_mem[r_rd_ptr];
  assign count           = r_count;

`ifndef SYNTHESIS
  a_count_max : assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= CNT_W'(DEPTH));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
    w_pop |-> (r_count != '0));
  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (r_out_vld && !out_if.rdy) |=> $stable(out_if.vld_data));
`endif

endmodule

// File: tb/tb_rdy_vld_fifo.sv
// Directed bench for rdy_vld_fifo with an 8-bit payload and DEPTH=4.
`timescale 1ns/1ps
module tb_rdy_vld_fifo;

  typedef logic [7:0] data_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] count;
  int         n_tests;
  int         n_fail;

  rdy_vld_if #(.vld_data_st(data_t)) in_if ();
  rdy_vld_if #(.vld_data_st(data_t)) out_if ();

  rdy_vld_fifo #(
    .vld_data_st(data_t),
    .DEPTH      (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_if (in_if),
    .out_if(out_if),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_if.vld = 1'b0;
    in_if.vld_data = '0;
    out_if.rdy = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (in_if.rdy !== 1'b0 || out_if.vld !== 1'b0 || count !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_hold: rdy=%b vld=%b count=%0d, want 0 0 0",
                 in_if.rdy, out_if.vld, count);
      end
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_if.rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_pre_edge: rdy=%b, want 0", in_if.rdy);
    end
    step();
    n_tests++;
    if (in_if.rdy !== 1'b1 || out_if.vld !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release_edge: rdy=%b vld=%b count=%0d, want 1 0 0",
               in_if.rdy, out_if.vld, count);
    end
  endtask

  task automatic test_latency();
    out_if.rdy = 1'b1;
    in_if.vld = 1'b1;
    in_if.vld_data = 8'hA1;
    step();
    in_if.vld = 1'b0;
    n_tests++;
    if (out_if.vld !== 1'b1 || out_if.vld_data !== 8'hA1 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL latency_push: vld=%b data=%h count=%0d, want 1 a1 1",
               out_if.vld, out_if.vld_data, count);
    end
    step();
    n_tests++;
    if (out_if.vld !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL latency_pop: vld=%b count=%0d, want 0 0", out_if.vld, count);
    end
  endtask

  task automatic test_fill();
    out_if.rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_if.vld = 1'b1;
      in_if.vld_data = data_t'(8'h10 + i);
      n_tests++;
      if (in_if.rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_rdy_%0d: rdy=%b, want 1", i, in_if.rdy);
      end
      step();
    end
    in_if.vld_data = 8'h15;
    n_tests++;
    if (count !== 3'd4 || in_if.rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: count=%0d rdy=%b, want 4 0", count, in_if.rdy);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (out_if.vld !== 1'b1 || out_if.vld_data !== 8'h11 || count !== 3'd4
          || in_if.rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d: vld=%b data=%h count=%0d rdy=%b, want 1 11 4 0",
                 i, out_if.vld, out_if.vld_data, count, in_if.rdy);
      end
    end
  endtask

  task automatic test_full_pop();
    // D5 is still presented with vld=1 from the fill test.
    out_if.rdy = 1'b1;
    step();
    n_tests++;
    if (count !== 3'd3 || in_if.rdy !== 1'b1 || out_if.vld_data !== 8'h12) begin
      n_fail++;
      $display("FAIL full_pop: count=%0d rdy=%b data=%h, want 3 1 12",
               count, in_if.rdy, out_if.vld_data);
    end
    step();
    in_if.vld = 1'b0;
    n_tests++;
    if (count !== 3'd3 || out_if.vld_data !== 8'h13) begin
      n_fail++;
      $display("FAIL refill: count=%0d data=%h, want 3 13", count, out_if.vld_data);
    end
    for (int i = 3; i <= 5; i++) begin
      n_tests++;
      if (out_if.vld !== 1'b1 || out_if.vld_data !== data_t'(8'h10 + i)) begin
        n_fail++;
        $display("FAIL drain_%0d: vld=%b data=%h, want 1 %h",
                 i, out_if.vld, out_if.vld_data, data_t'(8'h10 + i));
      end
      step();
    end
    n_tests++;
    if (out_if.vld !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty: vld=%b count=%0d, want 0 0", out_if.vld, count);
    end
  endtask

  task automatic test_wrap();
    int   next_val = 0;
    int   exp_val  = 0;
    int   model_cnt = 0;
    logic push_fire;
    logic pop_fire;
    in_if.vld = 1'b0;
    out_if.rdy = 1'b0;
    for (int cyc = 0; cyc < 3000 && exp_val < 100; cyc++) begin
      in_if.vld = (next_val < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_if.vld_data = data_t'(next_val);
      out_if.rdy = 1'($urandom_range(0, 1));
      #1;
      push_fire = in_if.vld && in_if.rdy;
      pop_fire  = out_if.vld && out_if.rdy;
      if (pop_fire) begin
        n_tests++;
        if (out_if.vld_data !== data_t'(exp_val)) begin
          n_fail++;
          $display("FAIL wrap_data: got %0d, want %0d", out_if.vld_data, exp_val);
        end
        exp_val++;
      end
      step();
      if (push_fire) begin
        next_val++;
        model_cnt++;
      end
      if (pop_fire) model_cnt--;
      n_tests++;
      if (count !== 3'(model_cnt) || count > 3'd4) begin
        n_fail++;
        $display("FAIL wrap_count: count=%0d, want %0d", count, model_cnt);
      end
    end
    in_if.vld = 1'b0;
    out_if.rdy = 1'b0;
    n_tests++;
    if (exp_val != 100) begin
      n_fail++;
      $display("FAIL wrap_done: received %0d values, want 100", exp_val);
    end
  endtask

  task automatic test_reset_mid();
    out_if.rdy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_if.vld = 1'b1;
      in_if.vld_data = data_t'(8'h30 + i);
      step();
    end
    in_if.vld = 1'b0;
    n_tests++;
    if (count !== 3'd3 || out_if.vld !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_prefill: count=%0d vld=%b, want 3 1", count, out_if.vld);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_if.vld !== 1'b0 || count !== 3'd0 || in_if.rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: vld=%b count=%0d rdy=%b, want 0 0 0",
               out_if.vld, count, in_if.rdy);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    in_if.vld = 1'b1;
    in_if.vld_data = 8'h41;
    out_if.rdy = 1'b1;
    step();
    in_if.vld = 1'b0;
    n_tests++;
    if (out_if.vld !== 1'b1 || out_if.vld_data !== 8'h41 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_first_after: vld=%b data=%h count=%0d, want 1 41 1",
               out_if.vld, out_if.vld_data, count);
    end
    step();
    n_tests++;
    if (out_if.vld !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_drain: vld=%b count=%0d, want 0 0", out_if.vld, count);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_latency();
    test_fill();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
